// File: rtl/oclib_ram_fifo_pkg.sv
// Shared sizing helpers for RAM-backed queues: output skid depth and occupancy counter width.
package oclib_ram_fifo_pkg;

  // One skid slot per RAM read pipeline stage, plus one for the registered read request.
  function automatic int skid_depth(input int latency);
    return latency + 1;
  endfunction

  function automatic int count_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/oclib_ram_fifo_if.sv
// Valid/ready streaming bundle for oclib_ram_fifo: write side (in*) and read side (out*).
interface oclib_ram_fifo_if #(
  parameter type DataType = logic [31:0]
);
  DataType inData;
  logic    inValid;
  logic    inReady;
  DataType outData;
  logic    outValid;
  logic    outReady;

  modport master (output inData, inValid, outReady, input inReady, outData, outValid);
  modport slave  (input inData, inValid, outReady, output inReady, outData, outValid);
endinterface

// File: rtl/oclib_ram_fifo_ram1r1w.sv
// One-write one-read synchronous RAM with a Latency-stage read pipeline; contents are never reset.
module oclib_ram1r1w #(
  parameter int  Width    = 32,
  parameter type DataType = logic [Width-1:0],
  parameter int  Depth    = 32,
  parameter int  Latency  = 1,
  parameter      Macro    = "auto",
  localparam int AddrW    = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             write,
  input  logic [AddrW-1:0] writeAddress,
  input  DataType          writeData,
  input  logic             read,
  input  logic [AddrW-1:0] readAddress,
  output DataType          readData
);

  // Hard macros hold their output between reads; the behavioural model samples every cycle.
  localparam bit HoldOutput = (Macro != "auto");

  DataType mem  [Depth];
  DataType pipe [Latency];

  always_ff @(posedge clock) begin
    if (write) mem[writeAddress] <= writeData;
  end

  always_ff @(posedge clock) begin
    if (read || !HoldOutput) pipe[0] <= mem[readAddress];
    for (int i = 1; i < Latency; i++) pipe[i] <= pipe[i-1];
  end

  assign readData = pipe[Latency-1];

endmodule

// File: rtl/oclib_ram_fifo.sv
// Single-clock FIFO built on oclib_ram1r1w with a flop skid buffer hiding the RAM read latency.
// Define OCLIB_RAM_FIFO_COUNT_EN to enable the registered occupancy output `count`.
module oclib_ram_fifo
  import oclib_ram_fifo_pkg::*;
#(
  parameter int  Width      = 32,
  parameter type DataType   = logic [Width-1:0],
  parameter int  Depth      = 32,
  parameter int  Latency    = 1,
  parameter      Macro      = "auto",
  localparam int SkidDepth  = skid_depth(Latency),
  localparam int Capacity   = Depth + SkidDepth,
  localparam int CountWidth = count_width(Capacity)
) (
  input  logic                  clock,
  input  logic                  reset,
  oclib_ram_fifo_if.slave       fifo_if,
  output logic [CountWidth-1:0] count
);

  localparam int AddrW    = $clog2(Depth);
  localparam int RamCntW  = AddrW + 1;
  localparam int SkidCntW = $clog2(SkidDepth + 1);
  localparam int SkidIdxW = $clog2(SkidDepth);

  logic [AddrW-1:0]    wr_ptr, rd_ptr, rd_addr_q;
  logic [RamCntW-1:0]  ram_count, ram_count_next;
  logic                in_ready_q, push, issue, rd_req_q;
  logic [Latency-1:0]  inflight;
  logic [SkidCntW-1:0] inflight_count, skid_count;
  logic [SkidIdxW-1:0] skid_wr_idx;
  logic                skid_push, skid_pop;
  DataType             rd_data;
  DataType             skid_mem [SkidDepth];

  assign push      = fifo_if.inValid & in_ready_q;
  assign skid_push = inflight[Latency-1];
  assign skid_pop  = fifo_if.outValid & fifo_if.outReady;

  // The registered read request counts as in flight so the skid can always absorb every issued read.
  always_comb begin
    inflight_count = SkidCntW'(rd_req_q);
    for (int i = 0; i < Latency; i++) inflight_count += SkidCntW'(inflight[i]);
  end

  assign issue = (ram_count != '0) && ((int'(inflight_count) + int'(skid_count)) < SkidDepth);

  always_comb begin
    ram_count_next = ram_count;
    if (push && !issue)      ram_count_next = ram_count + 1'b1;
    else if (!push && issue) ram_count_next = ram_count - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_addr_q  <= '0;
      ram_count  <= '0;
      in_ready_q <= 1'b0;
      rd_req_q   <= 1'b0;
      inflight   <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      rd_req_q   <= issue;
      rd_addr_q  <= rd_ptr;
      ram_count  <= ram_count_next;
      in_ready_q <= ram_count_next < RamCntW'(Depth);
      inflight   <= Latency'({inflight, rd_req_q});
    end
  end

  oclib_ram1r1w #(
    .Width    (Width),
    .DataType (DataType),
    .Depth    (Depth),
    .Latency  (Latency),
    .Macro    (Macro)
  ) u_ram (
    .clock        (clock),
    .write        (push),
    .writeAddress (wr_ptr),
    .writeData    (fifo_if.inData),
    .read         (rd_req_q),
    .readAddress  (rd_addr_q),
    .readData     (rd_data)
  );

  // Shifting skid: the head always sits in slot 0 so outData is a plain flop output.
  assign skid_wr_idx = SkidIdxW'(skid_count - SkidCntW'(skid_pop));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_count <= '0;
      for (int i = 0; i < SkidDepth; i++) skid_mem[i] <= '0;
    end else begin
      if (skid_pop) begin
        for (int i = 0; i < SkidDepth - 1; i++) skid_mem[i] <= skid_mem[i+1];
      end
      if (skid_push) skid_mem[skid_wr_idx] <= rd_data;
      if (skid_push && !skid_pop)      skid_count <= skid_count + 1'b1;
      else if (!skid_push && skid_pop) skid_count <= skid_count - 1'b1;
    end
  end

  assign fifo_if.inReady  = in_ready_q;
  assign fifo_if.outValid = (skid_count != '0);
  assign fifo_if.outData  = skid_mem[0];

`ifdef OCLIB_RAM_FIFO_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else       count <= CountWidth'(ram_count) + CountWidth'(inflight_count) + CountWidth'(skid_count);
  end
`else
  assign count = '0;
`endif

`ifdef SIMULATION
  always_ff @(posedge clock) begin
    if (!reset && fifo_if.inValid && !fifo_if.inReady)
      $error("oclib_ram_fifo: push attempted while full");
  end
`endif

endmodule
